// File: rtl/vending_change_dispenser_if.sv
// Request/refill and payout bus between the vending controller and the change dispenser.
// The dispenser's AMT_W parameter must match the AMT_W this interface is built with.
interface vending_change_dispenser_if #(
  parameter int AMT_W = 5
);
  logic             change_req;
  logic [AMT_W-1:0] change_amt;
  logic             refill;
  logic [AMT_W-1:0] ten_added;
  logic [AMT_W-1:0] five_added;
  logic             eject_ten;
  logic             eject_five;
  logic             busy;
  logic             done;
  logic             short_err;
  logic             bad_amt;
  logic [AMT_W-1:0] ten_stock;
  logic [AMT_W-1:0] five_stock;
  logic [AMT_W-1:0] paid_out;

  modport master (
    output change_req, change_amt, refill, ten_added, five_added,
    input  eject_ten, eject_five, busy, done, short_err, bad_amt,
           ten_stock, five_stock, paid_out
  );

  modport slave (
    input  change_req, change_amt, refill, ten_added, five_added,
    output eject_ten, eject_five, busy, done, short_err, bad_amt,
           ten_stock, five_stock, paid_out
  );
endinterface

// File: rtl/vending_change_dispenser.sv
// All-or-nothing coin payout: checks stock first, then pulses the 10/5 Rs solenoids one coin at a time.
// Coin stocks are kept locally and refilled by the service operator while idle.
module vending_change_dispenser #(
  parameter int AMT_W        = 5,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  vending_change_dispenser_if.slave bus
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
  localparam logic [AMT_W-1:0] C_TEN  = AMT_W'(10);
  localparam logic [AMT_W-1:0] C_FIVE = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PULSE,
    S_GAP,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AMT_W-1:0] r_rem;
  logic [AMT_W-1:0] r_ten_stock;
  logic [AMT_W-1:0] r_five_stock;
  logic [AMT_W-1:0] r_paid;
  logic             r_eject_ten;
  logic             r_eject_five;
  logic             r_busy;
  logic             r_done;
  logic             r_short;
  logic             r_bad;

  logic [AMT_W:0]   w_ten_sum;
  logic [AMT_W:0]   w_five_sum;
  logic [AMT_W-1:0] w_ten_new;
  logic [AMT_W-1:0] w_five_new;
  logic [AMT_W-1:0] w_t_need;
  logic [AMT_W-1:0] w_t;
  logic [AMT_W-1:0] w_f;
  logic [AMT_W-1:0] w_coin_val;
  logic             w_amt_bad;
  logic             w_pick_ten;

  always_comb begin
    w_ten_sum  = {1'b0, r_ten_stock} + {1'b0, bus.ten_added};
    w_five_sum = {1'b0, r_five_stock} + {1'b0, bus.five_added};
    w_ten_new  = w_ten_sum[AMT_W] ? '1 : w_ten_sum[AMT_W-1:0];
    w_five_new = w_five_sum[AMT_W] ? '1 : w_five_sum[AMT_W-1:0];
    // Greedy plan: as many tens as both amount and stock allow, fives cover the rest.
    w_t_need   = r_rem / C_TEN;
    w_t        = (w_t_need < r_ten_stock) ? w_t_need : r_ten_stock;
    w_f        = (r_rem - w_t * C_TEN) / C_FIVE;
    w_amt_bad  = (r_rem % C_FIVE) != '0;
    w_pick_ten = (r_rem >= C_TEN) && (r_ten_stock != '0);
    w_coin_val = r_eject_ten ? C_TEN : C_FIVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_ten_stock  <= '0;
      r_five_stock <= '0;
      r_paid       <= '0;
      r_eject_ten  <= 1'b0;
      r_eject_five <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_short      <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_short <= 1'b0;
      r_bad   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.refill) begin
            r_ten_stock  <= w_ten_new;
            r_five_stock <= w_five_new;
          end
          if (bus.change_req) begin
            r_rem   <= bus.change_amt;
            r_paid  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_amt_bad) begin
            r_bad   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (w_f > r_five_stock) begin
            r_short <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_eject_ten  <= w_pick_ten;
            r_eject_five <= !w_pick_ten;
            r_cnt        <= CNT_W'(PULSE_CYCLES - 1);
            r_state      <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_cnt == '0) begin
            if (r_eject_ten) r_ten_stock <= r_ten_stock - 1'b1;
            else             r_five_stock <= r_five_stock - 1'b1;
            r_rem        <= r_rem - w_coin_val;
            r_paid       <= r_paid + w_coin_val;
            r_eject_ten  <= 1'b0;
            r_eject_five <= 1'b0;
            r_cnt        <= CNT_W'(GAP_CYCLES - 1);
            r_state      <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rem == '0) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_eject_ten  <= w_pick_ten;
            r_eject_five <= !w_pick_ten;
            r_cnt        <= CNT_W'(PULSE_CYCLES - 1);
            r_state      <= S_PULSE;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_eject_ten  <= 1'b0;
          r_eject_five <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.eject_ten  = r_eject_ten;
  assign bus.eject_five = r_eject_five;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.short_err  = r_short;
  assign bus.bad_amt    = r_bad;
  assign bus.ten_stock  = r_ten_stock;
  assign bus.five_stock = r_five_stock;
  assign bus.paid_out   = r_paid;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: directed scenarios then random requests against an arithmetic payout model.
// Each period's solenoid/status pattern is predicted from the coin count and pulse/gap timing.
module tb_vending_change_dispenser;

  localparam int AMT_W = 5;
  localparam int P     = 2;
  localparam int G     = 3;
  localparam int SMAX  = (1 << AMT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ten = 0;
  int   m_five = 0;

  always #5 clk = ~clk;

  vending_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  vending_change_dispenser #(
    .AMT_W(AMT_W), .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic check_stock(input string tag);
    check({tag, "_ten_stock"}, 32'(bus.ten_stock), 32'(m_ten));
    check({tag, "_five_stock"}, 32'(bus.five_stock), 32'(m_five));
  endtask

  task automatic do_refill(input int rt, input int rf);
    @(posedge clk); #1;
    bus.refill = 1'b1; bus.ten_added = AMT_W'(rt); bus.five_added = AMT_W'(rf);
    @(posedge clk); #1;
    bus.refill = 1'b0; bus.ten_added = '0; bus.five_added = '0;
    m_ten  = sat(m_ten + rt);
    m_five = sat(m_five + rf);
    check_stock("refill");
    $display("refill +%0d/+%0d -> stock %0d/%0d", rt, rf, bus.ten_stock, bus.five_stock);
  endtask

  // kind: 0 = paid, 1 = short_err, 2 = bad_amt. inj > 0 pokes refill+req while busy in that period.
  task automatic do_req(input int amt, input bit use_ref, input int rt, input int rf, input int inj);
    int t, f, kind, fin, tend, idx, ph;
    logic [5:0] expv, obsv;
    if (use_ref) begin
      m_ten  = sat(m_ten + rt);
      m_five = sat(m_five + rf);
    end
    t = 0; f = 0;
    if (amt % 5 != 0) kind = 2;
    else begin
      t = (amt / 10 < m_ten) ? amt / 10 : m_ten;
      f = (amt - 10 * t) / 5;
      kind = (f > m_five) ? 1 : 0;
    end
    fin  = 2 + (t + f) * (P + G);
    tend = (kind == 0) ? fin + 2 : 4;
    @(posedge clk); #1;
    bus.change_req = 1'b1; bus.change_amt = AMT_W'(amt);
    if (use_ref) begin
      bus.refill = 1'b1; bus.ten_added = AMT_W'(rt); bus.five_added = AMT_W'(rf);
    end
    @(posedge clk); #1;
    bus.change_req = 1'b0; bus.refill = 1'b0; bus.ten_added = '0; bus.five_added = '0;
    for (int p = 1; p <= tend; p++) begin
      @(negedge clk);
      obsv = {bus.eject_ten, bus.eject_five, bus.busy, bus.done, bus.short_err, bus.bad_amt};
      expv = '0;
      if (kind != 0) begin
        expv[3] = (p == 1);
        expv[1] = (kind == 1) && (p == 2);
        expv[0] = (kind == 2) && (p == 2);
      end else begin
        expv[3] = (p <= fin);
        expv[2] = (p == fin);
        if (p >= 2 && p < fin) begin
          idx = (p - 2) / (P + G);
          ph  = (p - 2) % (P + G);
          if (ph < P) begin
            if (idx < t) expv[5] = 1'b1;
            else         expv[4] = 1'b1;
          end
        end
      end
      check($sformatf("amt%0d_p%0d_ten,five,busy,done,short,bad", amt, p), 32'(obsv), 32'(expv));
      if (p == inj) begin
        bus.change_req = 1'b1; bus.change_amt = AMT_W'(5);
        bus.refill = 1'b1; bus.ten_added = AMT_W'(5); bus.five_added = AMT_W'(5);
      end else if (p == inj + 1) begin
        bus.change_req = 1'b0; bus.refill = 1'b0; bus.ten_added = '0; bus.five_added = '0;
      end
    end
    bus.change_req = 1'b0; bus.refill = 1'b0; bus.ten_added = '0; bus.five_added = '0;
    if (kind == 0) begin
      m_ten  = m_ten - t;
      m_five = m_five - f;
    end
    check($sformatf("amt%0d_paid_out", amt), 32'(bus.paid_out), (kind == 0) ? 32'(amt) : 32'd0);
    check_stock($sformatf("amt%0d", amt));
    $display("req amt=%0d kind=%0d tens=%0d fives=%0d -> paid=%0d stock %0d/%0d",
             amt, kind, t, f, bus.paid_out, bus.ten_stock, bus.five_stock);
  endtask

  initial begin
    bus.change_req = 1'b0; bus.change_amt = '0;
    bus.refill = 1'b0; bus.ten_added = '0; bus.five_added = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.eject_ten, bus.eject_five, bus.busy, bus.done, bus.short_err, bus.bad_amt,
           bus.ten_stock, bus.five_stock, bus.paid_out}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two tens then one five, done 17 periods after the request edge.
    do_refill(3, 2);
    do_req(25, 1'b0, 0, 0, 0);
    // Drain to 0 tens / 2 fives, then 15 cannot be paid with fives alone.
    do_req(10, 1'b0, 0, 0, 0);
    do_refill(0, 1);
    do_req(15, 1'b0, 0, 0, 0);
    // Greedy fallback to fives once tens run out.
    do_refill(1, 2);
    do_req(30, 1'b0, 0, 0, 0);
    do_req(7, 1'b0, 0, 0, 0);
    do_req(0, 1'b0, 0, 0, 0);
    // Saturation, then refill/request while busy must be ignored.
    do_refill(30, 0);
    do_refill(5, 0);
    do_req(10, 1'b0, 0, 0, 3);
    // Same-cycle refill and request: CHECK sees the refilled stock.
    do_req(15, 1'b1, 0, 3, 0);

    // Asynchronous reset in the middle of a coin pulse.
    @(posedge clk); #1;
    bus.change_req = 1'b1; bus.change_amt = AMT_W'(20);
    @(posedge clk); #1;
    bus.change_req = 1'b0;
    repeat (2) @(negedge clk);
    check("midpulse_eject_ten", 32'(bus.eject_ten), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_eject_busy", {bus.eject_ten, bus.eject_five, bus.busy}, 32'd0);
    check("async_rst_stocks", {bus.ten_stock, bus.five_stock, bus.paid_out}, 32'd0);
    m_ten = 0; m_five = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    $display("reset mid-pulse -> stock %0d/%0d busy=%0d", bus.ten_stock, bus.five_stock, bus.busy);
    do_refill(2, 1);
    do_req(20, 1'b0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      int amt, rt, rf;
      if ($urandom_range(0, 2) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 4));
      amt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : 5 * $urandom_range(0, 6);
      rt  = $urandom_range(0, 2);
      rf  = $urandom_range(0, 3);
      do_req(amt, $urandom_range(0, 3) == 0, rt, rf, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vending_change_dispenser.md
Name: vending_change_dispenser

Overview:
Payout-side partner of vending_mach. It accepts a change/refund amount when the machine issues `give` or `cancel`, and drives the 10 Rs and 5 Rs coin-ejector solenoids one coin at a time. It keeps its own coin stock, refilled by the service operator, and guarantees all-or-nothing payout: no coin is ejected unless the full amount can be paid.

Parameters:
AMT_W, 5, width of amount and stock counters (max 31)
PULSE_CYCLES, 2, solenoid pulse width in clk cycles (>=1)
GAP_CYCLES, 3, idle cycles between consecutive coins (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
change_req  input  1  1-cycle strobe; payout request
change_amt  input  AMT_W  rupees to pay; sampled with change_req
refill  input  1  1-cycle strobe; add stock
ten_added  input  AMT_W  10 Rs coins added on refill
five_added  input  AMT_W  5 Rs coins added on refill
eject_ten  output  1  10 Rs solenoid drive
eject_five  output  1  5 Rs solenoid drive
busy  output  1  request in progress
done  output  1  1-cycle pulse; payout complete
short_err  output  1  1-cycle pulse; stock insufficient, nothing paid
bad_amt  output  1  1-cycle pulse; amount not a multiple of 5
ten_stock  output  AMT_W  10 Rs coins held
five_stock  output  AMT_W  5 Rs coins held
paid_out  output  AMT_W  rupees ejected for current/last request

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including stocks and paid_out. Reset mid-payout drops eject_* immediately and loses the remaining amount.
- All outputs registered. FSM states: IDLE, CHECK, PULSE, GAP, FIN.
- IDLE: busy=0.
  - refill: each stock += added, saturating at 2^AMT_W-1.
  - change_req: latch amt into rem, clear paid_out, go CHECK. busy=1 from the next cycle.
  - refill and change_req in the same cycle: both are taken; CHECK sees the refilled stock.
- CHECK (1 cycle). Let t = min(rem/10, ten_stock); f = (rem-10t)/5.
  - rem%5 != 0: bad_amt pulse, go IDLE.
  - rem==0: go FIN.
  - f > five_stock: short_err pulse, go IDLE, stocks unchanged.
  - Otherwise go PULSE.
- PULSE (PULSE_CYCLES cycles): coin choice is fixed on entry. Ten if rem>=10 and ten_stock>0, else five. The matching eject_* is high in every PULSE cycle; at most one eject_* is ever high. On the edge ending the last PULSE cycle: stock -= 1, rem -= value, paid_out += value. Go GAP.
- GAP (GAP_CYCLES cycles): eject_* low. At the end, go FIN if rem==0, else PULSE.
- FIN (1 cycle): done=1, busy=1. Next state IDLE.
- change_req and refill outside IDLE are ignored; no queueing.
- done, short_err and bad_amt are mutually exclusive and each lasts exactly 1 cycle.
- Latency: request edge → CHECK (1 cycle) → N coins × (PULSE_CYCLES+GAP_CYCLES) → FIN (1 cycle).

Test Plan:
1. Refill ten=3, five=2; req amt=25 → eject_ten pulses 2×, then eject_five 1×. Each pulse is 2 cycles with 3-cycle gaps. done at cycle 17 after the req edge. ten_stock=1, five_stock=1, paid_out=25.
2. Stock ten=0, five=2; req amt=15 → short_err 1 cycle after CHECK. No eject activity; stocks stay 0/2; busy for exactly 1 cycle.
3. Stock ten=1, five=4; req amt=30 → 1 ten then 4 fives (greedy fallback). Stocks 0/0, paid_out=30, done once.
4. req amt=7 → bad_amt pulse, no eject. Then req amt=0 → done 2 cycles after req, no eject.
5. Stock ten=30; refill ten_added=5 → ten_stock saturates at 31. Refill strobe while busy → stock unchanged. change_req while busy → ignored, only one done.
6. Pull reset low mid-PULSE during a 20 Rs payout → eject_* low and busy low asynchronously, stocks=0. After release, IDLE accepts a new refill and request normally.
